// File: rtl/ibuf_sched_pkg.sv
// Shared types and defaults for the ping-pong input-buffer scheduler.
package ibuf_sched_pkg;

  localparam int NHALF_DEF = 2;
  localparam int TW_DEF    = 16;

  typedef enum logic [1:0] {
    H_EMPTY   = 2'd0,
    H_FILLING = 2'd1,
    H_FULL    = 2'd2,
    H_READING = 2'd3
  } half_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/ibuf_sched_if.sv
// Control/handshake bundle between the scheduler, the layer sequencer,
// the tile loader and the tile consumer.
interface ibuf_sched_if
  import ibuf_sched_pkg::*;
#(
  parameter int TW = TW_DEF
);

  logic          start;
  logic [TW-1:0] cfg_tiles;
  logic          ld_req;
  logic          ld_sel;
  logic          ld_done;
  logic          cs_start;
  logic          cs_sel;
  logic          cs_done;
  logic          busy;
  logic          layer_done;
  logic          err;

  modport slave (
    input  start, cfg_tiles, ld_done, cs_done,
    output ld_req, ld_sel, cs_start, cs_sel, busy, layer_done, err
  );

  modport master (
    output start, cfg_tiles, ld_done, cs_done,
    input  ld_req, ld_sel, cs_start, cs_sel, busy, layer_done, err
  );

endinterface

// File: rtl/ibuf_half_tracker.sv
// Occupancy state of one input-buffer half.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   H_EMPTY   | free, may be targeted by the next load
//   H_FILLING | loader is writing this half
//   H_FULL    | tile present, waiting for the consumer
//   H_READING | consumer is reading this half
//
// avail_o is the state after this cycle's done events (or EMPTY when the
// layer is being (re)started); the scheduler makes its issue decisions on
// it so a freed or filled half can be reused on the very next edge.
module ibuf_half_tracker
  import ibuf_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        fill_done_i,
  input  logic        read_done_i,
  input  logic        ld_issue_i,
  input  logic        cs_issue_i,
  output half_state_e avail_o
);

  half_state_e state_q;
  half_state_e state_upd;
  half_state_e state_d;

  // apply completion events from the loader and consumer
  always_comb begin
    state_upd = state_q;
    if (fill_done_i && (state_q == H_FILLING)) state_upd = H_FULL;
    if (read_done_i && (state_q == H_READING)) state_upd = H_EMPTY;
  end

  assign avail_o = clr_i ? H_EMPTY : state_upd;

  // apply new load/consume commands on top of the completed state
  always_comb begin
    state_d = avail_o;
    if (ld_issue_i)      state_d = H_FILLING;
    else if (cs_issue_i) state_d = H_READING;
  end

  // state register, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= H_EMPTY;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/ibuf_sched.sv
// Ping-pong input-buffer scheduler: alternates tile loads and tile reads
// between two buffer halves so loading the next tile overlaps consumption.
//
//   state  | meaning
//   -------+-----------------------------------------------------
//   S_IDLE | waiting for start; start also issues the first load
//   S_RUN  | loading / consuming tiles until consumed == tiles
//   S_FIN  | one cycle with layer_done high, then back to idle
module ibuf_sched
  import ibuf_sched_pkg::*;
#(
  parameter int NHALF = NHALF_DEF,
  parameter int TW    = TW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  ibuf_sched_if.slave bus
);

  sched_state_e  state_q;
  logic [TW-1:0] tiles_q;
  logic [TW-1:0] issued_q,   issued_d;
  logic [TW-1:0] consumed_q, consumed_d;
  logic          ld_ptr_q,   ld_ptr_d;
  logic          cs_ptr_q,   cs_ptr_d;
  logic          ld_out_q,   ld_out_d;
  logic          cs_out_q,   cs_out_d;
  logic          ld_sel_q,   ld_sel_d;
  logic          cs_sel_q,   cs_sel_d;
  logic          err_q,      err_d;
  logic          ld_req_q;
  logic          cs_start_q;
  logic          busy_q;
  logic          layer_done_q;

  logic          accept;
  logic          run;
  logic          ld_fin;
  logic          cs_fin;
  logic [TW-1:0] tiles_eff;
  logic [TW-1:0] issued_base;
  logic          ld_ptr_base;
  logic          cs_ptr_base;
  logic          ld_out_base;
  logic          cs_out_base;
  logic          ld_issue;
  logic          cs_issue;

  half_state_e   half_avail [NHALF];

  assign accept = (state_q == S_IDLE) && bus.start;
  assign run    = (state_q == S_RUN);
  assign ld_fin = bus.ld_done && ld_out_q;
  assign cs_fin = bus.cs_done && cs_out_q;

  for (genvar h = 0; h < NHALF; h++) begin : g_half
    ibuf_half_tracker u_half (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (accept),
      .fill_done_i (ld_fin && (ld_sel_q == 1'(h))),
      .read_done_i (cs_fin && (cs_sel_q == 1'(h))),
      .ld_issue_i  (ld_issue && (ld_ptr_base == 1'(h))),
      .cs_issue_i  (cs_issue && (cs_ptr_base == 1'(h))),
      .avail_o     (half_avail[h])
    );
  end

  // issue decisions and next-state of counters, pointers and flags;
  // an accepted start behaves like a fresh RUN so the first load
  // leaves on the same edge
  always_comb begin
    tiles_eff   = accept ? bus.cfg_tiles : tiles_q;
    issued_base = accept ? '0 : issued_q;
    ld_ptr_base = accept ? 1'b0 : ld_ptr_q;
    cs_ptr_base = accept ? 1'b0 : cs_ptr_q;
    ld_out_base = !accept && ld_out_q && !bus.ld_done;
    cs_out_base = !accept && cs_out_q && !bus.cs_done;

    ld_issue = (accept || run) && !ld_out_base && (issued_base < tiles_eff)
               && (half_avail[ld_ptr_base] == H_EMPTY);
    cs_issue = run && !cs_out_base && (half_avail[cs_ptr_base] == H_FULL);

    issued_d   = issued_base + TW'(ld_issue);
    consumed_d = accept ? '0 : consumed_q + TW'(cs_fin);
    ld_ptr_d   = ld_ptr_base ^ ld_issue;
    cs_ptr_d   = cs_ptr_base ^ cs_issue;
    ld_out_d   = ld_out_base || ld_issue;
    cs_out_d   = cs_out_base || cs_issue;
    ld_sel_d   = ld_issue ? ld_ptr_base : ld_sel_q;
    cs_sel_d   = cs_issue ? cs_ptr_base : cs_sel_q;
    err_d      = (err_q && !accept)
                 || (bus.ld_done && !ld_out_q)
                 || (bus.cs_done && !cs_out_q);
  end

  // top FSM plus all registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tiles_q      <= '0;
      issued_q     <= '0;
      consumed_q   <= '0;
      ld_ptr_q     <= 1'b0;
      cs_ptr_q     <= 1'b0;
      ld_out_q     <= 1'b0;
      cs_out_q     <= 1'b0;
      ld_sel_q     <= 1'b0;
      cs_sel_q     <= 1'b0;
      err_q        <= 1'b0;
      ld_req_q     <= 1'b0;
      cs_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      issued_q     <= issued_d;
      consumed_q   <= consumed_d;
      ld_ptr_q     <= ld_ptr_d;
      cs_ptr_q     <= cs_ptr_d;
      ld_out_q     <= ld_out_d;
      cs_out_q     <= cs_out_d;
      ld_sel_q     <= ld_sel_d;
      cs_sel_q     <= cs_sel_d;
      err_q        <= err_d;
      ld_req_q     <= ld_issue;
      cs_start_q   <= cs_issue;
      layer_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_RUN;
            tiles_q <= bus.cfg_tiles;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (consumed_q == tiles_q) begin
            state_q      <= S_FIN;
            layer_done_q <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_req     = ld_req_q;
  assign bus.ld_sel     = ld_sel_q;
  assign bus.cs_start   = cs_start_q;
  assign bus.cs_sel     = cs_sel_q;
  assign bus.busy       = busy_q;
  assign bus.layer_done = layer_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ibuf_sched.sv
// Scoreboard bench for ibuf_sched: directed layers push their hand-derived
// pulse schedule into queues, a negedge monitor pops and compares, and a
// reference occupancy model checks that halves are only loaded when empty
// and only read when full.
module tb_ibuf_sched;
  import ibuf_sched_pkg::*;

  localparam int TW      = 16;
  localparam int M_EMPTY = 0;
  localparam int M_FILL  = 1;
  localparam int M_FULL  = 2;
  localparam int M_READ  = 3;

  typedef struct {
    int sel;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t exp_ld[$];
  exp_t exp_cs[$];
  int   exp_layer[$];

  int   mdl [2];
  int   m_ld_out, m_ld_sel, m_cs_out, m_cs_sel;

  int   ld_delay, cs_delay, ld_cnt, cs_cnt;
  bit   ld_pend, cs_pend;
  int   base;
  int   k;

  ibuf_sched_if #(.TW(TW)) bus ();

  ibuf_sched #(.NHALF(2), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ld_at(input int sel, input int off);
    exp_t e;
    e.sel = sel;
    e.cyc = base + off;
    exp_ld.push_back(e);
  endtask

  task automatic exp_cs_at(input int sel, input int off);
    exp_t e;
    e.sel = sel;
    e.cyc = base + off;
    exp_cs.push_back(e);
  endtask

  // advance one cycle; the loader/consumer responders answer each request
  // after ld_delay / cs_delay cycles (0 = same cycle the request is seen)
  task automatic step();
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.cfg_tiles = 16'hBEEF;
    bus.ld_done   = 1'b0;
    bus.cs_done   = 1'b0;
    if (!rst_n) begin
      ld_pend = 1'b0;
      cs_pend = 1'b0;
    end else begin
      if (bus.ld_req === 1'b1) begin
        ld_pend = 1'b1;
        ld_cnt  = ld_delay;
      end
      if (ld_pend) begin
        if (ld_cnt == 0) begin
          bus.ld_done = 1'b1;
          ld_pend     = 1'b0;
        end else ld_cnt--;
      end
      if (bus.cs_start === 1'b1) begin
        cs_pend = 1'b1;
        cs_cnt  = cs_delay;
      end
      if (cs_pend) begin
        if (cs_cnt == 0) begin
          bus.cs_done = 1'b1;
          cs_pend     = 1'b0;
        end else cs_cnt--;
      end
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_start(input int n);
    base          = cyc;
    bus.start     = 1'b1;
    bus.cfg_tiles = TW'(n);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ld_req"},     int'(bus.ld_req),     0);
    check({tag, " ld_sel"},     int'(bus.ld_sel),     0);
    check({tag, " cs_start"},   int'(bus.cs_start),   0);
    check({tag, " cs_sel"},     int'(bus.cs_sel),     0);
    check({tag, " busy"},       int'(bus.busy),       0);
    check({tag, " layer_done"}, int'(bus.layer_done), 0);
    check({tag, " err"},        int'(bus.err),        0);
  endtask

  // monitor: pop expected pulses and track reference half occupancy
  initial begin
    exp_t e;
    int   lc;
    mdl[0] = M_EMPTY; mdl[1] = M_EMPTY;
    m_ld_out = 0; m_ld_sel = 0; m_cs_out = 0; m_cs_sel = 0;
    forever begin
      @(negedge clk);
      if (bus.ld_req === 1'b1) begin
        check("ld_req expected", int'(exp_ld.size() > 0), 1);
        if (exp_ld.size() > 0) begin
          e = exp_ld.pop_front();
          check("ld_sel", int'(bus.ld_sel), e.sel);
          check("ld_req cycle", cyc, e.cyc);
        end
        check("ld target half empty", mdl[bus.ld_sel], M_EMPTY);
        mdl[bus.ld_sel] = M_FILL;
        m_ld_out = 1;
        m_ld_sel = int'(bus.ld_sel);
      end
      if (bus.cs_start === 1'b1) begin
        check("cs_start expected", int'(exp_cs.size() > 0), 1);
        if (exp_cs.size() > 0) begin
          e = exp_cs.pop_front();
          check("cs_sel", int'(bus.cs_sel), e.sel);
          check("cs_start cycle", cyc, e.cyc);
        end
        check("cs source half full", mdl[bus.cs_sel], M_FULL);
        mdl[bus.cs_sel] = M_READ;
        m_cs_out = 1;
        m_cs_sel = int'(bus.cs_sel);
      end
      if (bus.layer_done === 1'b1) begin
        check("layer_done expected", int'(exp_layer.size() > 0), 1);
        if (exp_layer.size() > 0) begin
          lc = exp_layer.pop_front();
          check("layer_done cycle", cyc, lc);
        end
        check("busy during layer_done", int'(bus.busy), 1);
      end
      if (bus.ld_done === 1'b1 && m_ld_out == 1) begin
        mdl[m_ld_sel] = M_FULL;
        m_ld_out = 0;
      end
      if (bus.cs_done === 1'b1 && m_cs_out == 1) begin
        mdl[m_cs_sel] = M_EMPTY;
        m_cs_out = 0;
      end
      if (rst_n !== 1'b1) begin
        mdl[0] = M_EMPTY; mdl[1] = M_EMPTY;
        m_ld_out = 0; m_cs_out = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // directed stimulus
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.cfg_tiles = '0; bus.ld_done = 1'b0; bus.cs_done = 1'b0;
    ld_delay = 0; cs_delay = 0; ld_cnt = 0; cs_cnt = 0;
    ld_pend = 1'b0; cs_pend = 1'b0; base = 0; k = 0;

    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();
    check_idle("after release");

    // single tile, loader and consumer each take 2 cycles
    ld_delay = 2; cs_delay = 2;
    step();
    do_start(1);
    exp_ld_at(0, 1);
    exp_cs_at(0, 4);
    exp_layer.push_back(base + 8);
    wait_to(base + 1);
    check("t1 busy", int'(bus.busy), 1);
    wait_to(base + 9);
    check("t1 busy after", int'(bus.busy), 0);
    check("t1 err", int'(bus.err), 0);

    // four tiles, zero-delay loader and consumer
    ld_delay = 0; cs_delay = 0;
    step();
    do_start(4);
    exp_ld_at(0, 1); exp_ld_at(1, 2); exp_ld_at(0, 3); exp_ld_at(1, 4);
    exp_cs_at(0, 2); exp_cs_at(1, 3); exp_cs_at(0, 4); exp_cs_at(1, 5);
    exp_layer.push_back(base + 7);
    wait_to(base + 9);
    check("t4 busy after", int'(bus.busy), 0);

    // three tiles, slow consumer: no reload of half 0 while it is read
    ld_delay = 0; cs_delay = 20;
    step();
    do_start(3);
    exp_ld_at(0, 1); exp_ld_at(1, 2); exp_ld_at(0, 23);
    exp_cs_at(0, 2); exp_cs_at(1, 23); exp_cs_at(0, 44);
    exp_layer.push_back(base + 66);
    wait_to(base + 10);
    check("slow ld_sel hold", int'(bus.ld_sel), 1);
    check("slow cs_sel hold", int'(bus.cs_sel), 0);
    wait_to(base + 68);
    check("slow busy after", int'(bus.busy), 0);

    // four tiles, ld_done and cs_done coincide; start while busy ignored
    ld_delay = 1; cs_delay = 1;
    step();
    do_start(4);
    exp_ld_at(0, 1); exp_ld_at(1, 3); exp_ld_at(0, 5); exp_ld_at(1, 7);
    exp_cs_at(0, 3); exp_cs_at(1, 5); exp_cs_at(0, 7); exp_cs_at(1, 9);
    exp_layer.push_back(base + 12);
    wait_to(base + 4);
    bus.start = 1'b1;
    bus.cfg_tiles = 16'd9;
    wait_to(base + 5);
    check("busy start no err", int'(bus.err), 0);
    wait_to(base + 14);
    check("coinc busy after", int'(bus.busy), 0);

    // zero tiles
    step();
    do_start(0);
    exp_layer.push_back(base + 2);
    wait_to(base + 1);
    check("zero busy", int'(bus.busy), 1);
    wait_to(base + 3);
    check("zero busy after", int'(bus.busy), 0);

    // spurious cs_done while idle
    step();
    bus.cs_done = 1'b1;
    k = cyc;
    step();
    check("spurious err set", int'(bus.err), 1);
    check("spurious busy", int'(bus.busy), 0);
    wait_to(k + 5);
    check("spurious err sticky", int'(bus.err), 1);

    // five tiles, reset mid-layer
    ld_delay = 1; cs_delay = 2;
    step();
    do_start(5);
    exp_ld_at(0, 1); exp_ld_at(1, 3);
    exp_cs_at(0, 3);
    wait_to(base + 1);
    check("start clears err", int'(bus.err), 0);
    check("t5 busy", int'(bus.busy), 1);
    wait_to(base + 4);
    rst_n = 1'b0;
    step();
    check_idle("mid reset a");
    step();
    check_idle("mid reset b");
    rst_n = 1'b1;
    step();
    check_idle("mid reset released");
    bus.ld_done = 1'b1;
    step();
    check("late ld_done err", int'(bus.err), 1);
    repeat (10) step();
    check("post reset busy", int'(bus.busy), 0);

    check("ld queue drained", exp_ld.size(), 0);
    check("cs queue drained", exp_cs.size(), 0);
    check("layer queue drained", exp_layer.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibuf_sched.md
IBUF_SCHED -- requirements
Module: ibuf_sched

Interface
REQ-001 Parameter NHALF, default 2, number of ping-pong input-buffer halves (fixed at 2; the select is 1 bit).
REQ-002 Parameter TW, default 16, width of the tile counters and of cfg_tiles.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a layer; sampled only in IDLE.
REQ-006 cfg_tiles  input  TW  number of tiles in the layer; captured when start is accepted.
REQ-007 ld_req  output  1  one-cycle pulse; commands the loader to fill half ld_sel.
REQ-008 ld_sel  output  1  target half of the current or most recent ld_req.
REQ-009 ld_done  input  1  one-cycle pulse; the loader has finished the outstanding fill.
REQ-010 cs_start  output  1  one-cycle pulse to the buffer interface (drives its blkend); the tile in half cs_sel is ready.
REQ-011 cs_sel  output  1  half to read (drives the read-port select).
REQ-012 cs_done  input  1  one-cycle pulse; the consumer has finished the outstanding tile.
REQ-013 busy  output  1  high while not in IDLE.
REQ-014 layer_done  output  1  one-cycle pulse when the last tile is consumed.
REQ-015 err  output  1  sticky protocol-error flag; cleared only by reset or an accepted start.

Function
REQ-016 Top FSM states: IDLE, RUN, FIN. IDLE->RUN on start; RUN->FIN when consumed count equals the captured cfg_tiles; FIN->IDLE unconditionally after 1 cycle, with layer_done high in FIN.
REQ-017 Accepting start with cfg_tiles==0 gives RUN for exactly 1 cycle, then FIN; no ld_req or cs_start is issued.
REQ-018 Each half has a state: EMPTY, FILLING, FULL, READING. All halves are EMPTY on entry to RUN.
REQ-019 Load issue: in RUN, when there is no outstanding load, issued<cfg_tiles, and half ld_ptr is EMPTY, assert ld_req with ld_sel=ld_ptr for 1 cycle; that half becomes FILLING; issued increments; ld_ptr toggles.
REQ-020 ld_done with a load outstanding: FILLING half -> FULL; outstanding load clears.
REQ-021 Consume issue: when there is no outstanding consume and half cs_ptr is FULL, assert cs_start with cs_sel=cs_ptr for 1 cycle; that half becomes READING; cs_ptr toggles.
REQ-022 cs_done with a consume outstanding: READING half -> EMPTY; consumed increments.
REQ-023 Latency: ld_req follows start by 1 cycle; cs_start follows ld_done by 1 cycle; a reload of a freed half follows cs_done by 1 cycle.
REQ-024 ld_done and cs_done in the same cycle are both processed in that cycle.
REQ-025 ld_req and cs_start may be asserted in the same cycle, for different halves.
REQ-026 A half is never loaded while READING and never read while FILLING.
REQ-027 cs_sel and ld_sel hold their values between pulses.
REQ-028 ld_done without an outstanding load, or cs_done without an outstanding consume, is ignored except that it sets err.
REQ-029 start while busy is ignored; it does not set err.
REQ-030 The issued and consumed counters are TW bits and never exceed cfg_tiles. ld_ptr and cs_ptr wrap 1->0.

Reset
REQ-031 When rst_n is low at a clock edge: state=IDLE; all halves EMPTY; counters, pointers and outstanding flags cleared.
REQ-032 Outputs while rst_n is low and in the cycle after release: ld_req=0, ld_sel=0, cs_start=0, cs_sel=0, busy=0, layer_done=0, err=0.
REQ-033 A reset in the middle of a layer abandons the layer with no layer_done. ld_done or cs_done arriving after the reset sets err.

Structure
REQ-034 A shared package holds the half-state enum (EMPTY/FILLING/FULL/READING), the top-FSM enum, and the NHALF and TW defaults.
REQ-035 One sub-module, ibuf_half_tracker, holds the per-half state; it is instantiated NHALF times.
REQ-036 All outputs are registered.

Verification
REQ-037 Reset, then start with cfg_tiles=1 -> ld_req at +1 with ld_sel=0; ld_done -> cs_start at +1 with cs_sel=0; cs_done -> layer_done at +2 (RUN->FIN transition, then FIN); busy back to 0.
REQ-038 cfg_tiles=4 with zero-delay loader and consumer -> ld_sel sequence 0,1,0,1; cs_sel sequence 0,1,0,1; exactly 4 of each pulse; one layer_done.
REQ-039 cfg_tiles=3 with slow consumer (cs_done 20 cycles after cs_start) -> at most 2 halves non-EMPTY at any time; no ld_req to a READING half.
REQ-040 ld_done and cs_done in the same cycle (cfg_tiles=4) -> both halves update in that cycle; the next ld_req and cs_start both appear 1 cycle later.
REQ-041 cfg_tiles=0 -> layer_done 2 cycles after start; no ld_req or cs_start.
REQ-042 Spurious cs_done in IDLE -> err=1 and stays 1 until the next accepted start. rst_n low mid-layer (cfg_tiles=5) -> all outputs at reset values and IDLE next cycle.
